// File: rtl/uart_pkg.sv
// Shared UART-side types: arbiter FSM encoding and default parameter values.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    GAP
  } arb_state_t;

  localparam int N_REQ_DEFAULT     = 4;
  localparam int GAP_TICKS_DEFAULT = 1;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted req_i bit at or after ptr_i, wrapping mod N.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             found_o,
  output logic [IDX_W-1:0] idx_o
);

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int i = 0; i < N; i++) begin
      int sum;
      logic [IDX_W-1:0] cand;
      sum  = int'(ptr_i) + i;
      cand = IDX_W'((sum >= N) ? sum - N : sum);
      if (!found_o && req_i[cand]) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx among N_REQ byte producers: round-robin grant, per-message lock via req_last,
// and an idle gap of GAP_TICKS baud ticks after every frame before the next grant.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ     = N_REQ_DEFAULT,
  parameter int GAP_TICKS = GAP_TICKS_DEFAULT,
  parameter int GAP_W     = 4,
  parameter int ID_W      = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_data,
  input  logic [N_REQ-1:0]     req_last,
  output logic [N_REQ-1:0]     req_ready,
  input  logic                 tx_enb,
  input  logic                 tx_busy,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  output logic [ID_W-1:0]      grant_id,
  output logic                 locked
);

  arb_state_t       state_q, state_d;
  logic [ID_W-1:0]  grant_q, grant_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic             locked_q, locked_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             pick_found;
  logic [ID_W-1:0]  pick_idx;
  logic [7:0]       grant_byte;

  rr_pick #(.N(N_REQ), .IDX_W(ID_W)) u_pick (
    .req_i   (req_valid),
    .ptr_i   (rr_ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  assign grant_byte = req_data[{grant_q, 3'b000} +: 8];

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_ptr_d  = rr_ptr_q;
    locked_d  = locked_q;
    gap_d     = gap_q;
    tx_data_d = tx_data_q;
    tx_start  = 1'b0;
    req_ready = '0;
    unique case (state_q)
      IDLE: begin
        // While locked, grant_q doubles as the lock owner and nobody else is scanned.
        if (locked_q) begin
          if (req_valid[grant_q]) state_d = ISSUE;
        end else if (pick_found) begin
          grant_d = pick_idx;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        tx_start           = !rst;
        req_ready[grant_q] = !rst;
        tx_data_d          = grant_byte;
        if (req_last[grant_q]) begin
          locked_d = 1'b0;
          rr_ptr_d = (grant_q == ID_W'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
        end else begin
          locked_d = 1'b1;
        end
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          if (GAP_TICKS == 0) begin
            state_d = IDLE;
          end else begin
            gap_d   = GAP_W'(GAP_TICKS);
            state_d = GAP;
          end
        end
      end
      GAP: begin
        if (tx_enb) begin
          gap_d = gap_q - 1'b1;
          if (gap_q == GAP_W'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      rr_ptr_q  <= '0;
      locked_q  <= 1'b0;
      gap_q     <= '0;
      tx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_ptr_q  <= rr_ptr_d;
      locked_q  <= locked_d;
      gap_q     <= gap_d;
      tx_data_q <= tx_data_d;
    end
  end

  // Byte is driven straight from the grantee during ISSUE, then held for uart_tx.
  assign tx_data  = tx_start ? grant_byte : tx_data_q;
  assign grant_id = grant_q;
  assign locked   = locked_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: scoreboard of (grantee, byte, lock) per tx_start on a GAP_TICKS=1
// instance with a uart_tx busy model, plus directed gap timing on GAP_TICKS=3 and 0 instances.
module tb_uart_tx_arbiter;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] dat;
    logic       lk;
  } exp_t;

  localparam int GAP_MAIN = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [3:0]  req_valid, req_last, req_ready;
  logic [31:0] req_data;
  logic        tx_enb, tx_busy, tx_start, locked;
  logic [7:0]  tx_data;
  logic [1:0]  grant_id;

  uart_tx_arbiter #(.N_REQ(4), .GAP_TICKS(GAP_MAIN), .GAP_W(4), .ID_W(2)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .tx_enb(tx_enb), .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
    .grant_id(grant_id), .locked(locked)
  );

  // Gap-timing instances: index 0 has GAP_TICKS=3, index 1 has GAP_TICKS=0.
  logic [3:0]  gv [2];
  logic [3:0]  gl [2];
  logic [3:0]  grdy [2];
  logic [31:0] gd [2];
  logic        gbusy [2];
  logic        gstart [2];
  logic        glock [2];
  logic [7:0]  gtx [2];
  logic [1:0]  gid [2];
  logic        g_enb;

  for (genvar gi = 0; gi < 2; gi++) begin : g_gap
    uart_tx_arbiter #(.N_REQ(4), .GAP_TICKS((gi == 0) ? 3 : 0), .GAP_W(4), .ID_W(2)) u_gap (
      .clk(clk), .rst(rst),
      .req_valid(gv[gi]), .req_data(gd[gi]), .req_last(gl[gi]), .req_ready(grdy[gi]),
      .tx_enb(g_enb), .tx_busy(gbusy[gi]), .tx_start(gstart[gi]), .tx_data(gtx[gi]),
      .grant_id(gid[gi]), .locked(glock[gi])
    );
  end

  int nerr = 0;
  int nchk = 0;
  exp_t exp_q[$];
  logic [8:0] prod_q [4][$];
  int frame_len = 20;
  int start_cnt = 0;
  int rdy1_cnt = 0;
  int last_start_cyc = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    nchk++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic put(input int r, input logic [7:0] d, input logic l);
    prod_q[r].push_back({l, d});
  endtask

  task automatic exp_push(input logic [1:0] id, input logic [7:0] d, input logic lk);
    exp_t e;
    e.id = id; e.dat = d; e.lk = lk;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int bound);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < bound) begin @(negedge clk); n++; end
    chk(name, exp_q.size(), 0);
    repeat (3) @(negedge clk);
    n = 0;
    while (tx_busy && n < bound) begin @(negedge clk); n++; end
    chk({name, "_busy_fall"}, tx_busy, 0);
    repeat (12) @(negedge clk);
  endtask

  // Baud ticks: every 4 clk for the main instance, every 10 clk for the gap instances.
  initial begin
    tx_enb = 1'b0; g_enb = 1'b0;
    forever begin
      @(posedge clk); #1;
      tx_enb = (cyc % 4 == 0);
      g_enb  = (cyc % 10 == 0);
    end
  end

  // Producers: present the queue head, pop it after a req_ready pulse.
  initial begin
    logic [3:0] acc;
    req_valid = '0; req_data = '0; req_last = '0;
    forever begin
      @(negedge clk); acc = req_ready;
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
        if (acc[i] && prod_q[i].size() != 0) void'(prod_q[i].pop_front());
        if (prod_q[i].size() != 0) begin
          req_valid[i]        = 1'b1;
          req_data[8*i +: 8]  = prod_q[i][0][7:0];
          req_last[i]         = prod_q[i][0][8];
        end else begin
          req_valid[i] = 1'b0;
          req_last[i]  = 1'b0;
        end
      end
    end
  end

  // uart_tx model: busy from the cycle after tx_start for frame_len clk; dropped by reset.
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start && !rst) begin
        @(posedge clk); #1;
        if (!rst) begin
          tx_busy = 1'b1;
          for (int k = 0; k < frame_len; k++) begin
            @(posedge clk); #1;
            if (rst) break;
          end
          tx_busy = 1'b0;
        end
      end
    end
  end

  // Monitor: scoreboard pop per tx_start, req_ready invariant, and gap since last frame.
  initial begin
    exp_t e;
    bit   frame_open;
    int   gap_ticks;
    logic busy_prev;
    frame_open = 1'b0; gap_ticks = 99; busy_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("ready_onehot_issue_only",
            ((req_ready & (req_ready - 4'd1)) == 4'd0) && (req_ready == 4'd0 || tx_start), 1);
        if (rst) chk("no_start_in_reset", tx_start, 0);
        if (req_ready[1]) rdy1_cnt++;
        if (tx_start && !rst) begin
          start_cnt++;
          last_start_cyc = cyc;
          chk("gap_before_start", (!frame_open && gap_ticks >= GAP_MAIN), 1);
          if (exp_q.size() == 0) begin
            nchk++; nerr++;
            $display("FAIL unexpected_start: got byte 0x%0h grant %0d, required no tx_start", tx_data, grant_id);
          end else begin
            e = exp_q.pop_front();
            chk("tx_data", tx_data, e.dat);
            chk("grant_id", grant_id, e.id);
            chk("req_ready", req_ready, 4'b0001 << e.id);
            chk("locked_in_issue", locked, e.lk);
          end
          frame_open = 1'b1;
        end
        if (tx_enb && !tx_busy && !busy_prev && !frame_open) gap_ticks++;
        if (busy_prev && !tx_busy) begin frame_open = 1'b0; gap_ticks = 0; end
        busy_prev = tx_busy;
        if (rst) begin frame_open = 1'b0; gap_ticks = 99; end
      end
    end
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      gv[i] = '0; gl[i] = '0; gd[i] = '0; gbusy[i] = 1'b0;
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", nerr);
    $fatal(1, "watchdog");
  end

  initial begin
    int t_push, s0, r0, n;
    @(posedge clk); #1; mon_en = 1'b1;
    @(negedge clk);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_locked", locked, 0);
    chk("rst_req_ready", req_ready, 0);
    rst = 1'b0;

    // Single byte and grant-to-start latency.
    @(negedge clk);
    put(0, 8'h55, 1'b1); exp_push(2'd0, 8'h55, 1'b0); t_push = cyc;
    wait_drain("t1_drain", 300);
    chk("t1_latency_clk", last_start_cyc - (t_push + 1) + 1, 2);

    // Round-robin from pointer 0, then wrap, then pointer 2 with requests 0 and 1.
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      put(i, 8'(8'hA0 + i), 1'b1); exp_push(2'(i), 8'(8'hA0 + i), 1'b0);
    end
    wait_drain("t2_rr", 1000);
    @(negedge clk); put(0, 8'hA4, 1'b1); exp_push(2'd0, 8'hA4, 1'b0);
    wait_drain("t2_wrap", 300);
    @(negedge clk); put(1, 8'hB1, 1'b1); exp_push(2'd1, 8'hB1, 1'b0);
    wait_drain("t2_ptr", 300);
    @(negedge clk);
    put(0, 8'hC0, 1'b1); put(1, 8'hC1, 1'b1);
    exp_push(2'd0, 8'hC0, 1'b0); exp_push(2'd1, 8'hC1, 1'b0);
    wait_drain("t2_ptr2", 600);

    // Locked three-byte message from req1 while req0 and req2 wait.
    do_reset();
    @(negedge clk);
    put(1, 8'h10, 1'b0); put(1, 8'h11, 1'b0); put(1, 8'h12, 1'b1);
    exp_push(2'd1, 8'h10, 1'b0); exp_push(2'd1, 8'h11, 1'b1); exp_push(2'd1, 8'h12, 1'b1);
    exp_push(2'd2, 8'h22, 1'b0); exp_push(2'd0, 8'h20, 1'b0);
    n = 0;
    while (exp_q.size() > 4 && n < 100) begin @(negedge clk); n++; end
    chk("t3_first_grant", exp_q.size(), 4);
    put(0, 8'h20, 1'b1); put(2, 8'h22, 1'b1);
    wait_drain("t3_lock", 1500);
    chk("t3_unlocked", locked, 0);

    // Reset while locked in WAIT_DONE.
    @(negedge clk);
    put(3, 8'h30, 1'b0); put(3, 8'h31, 1'b1); exp_push(2'd3, 8'h30, 1'b0);
    n = 0;
    while (!(locked && tx_busy) && n < 200) begin @(negedge clk); n++; end
    chk("t5_locked_busy", locked && tx_busy, 1);
    repeat (2) @(negedge clk);
    rst = 1'b1; prod_q[3].delete();
    repeat (2) @(negedge clk);
    chk("t5_rst_tx_start", tx_start, 0);
    chk("t5_rst_req_ready", req_ready, 0);
    chk("t5_rst_tx_data", tx_data, 0);
    chk("t5_rst_grant_id", grant_id, 0);
    chk("t5_rst_locked", locked, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    put(2, 8'h2E, 1'b1); exp_push(2'd2, 8'h2E, 1'b0);
    wait_drain("t5_after_reset", 300);

    // Long frame: exactly one start and one ready pulse.
    frame_len = 100; s0 = start_cnt; r0 = rdy1_cnt;
    @(negedge clk); put(1, 8'h66, 1'b1); exp_push(2'd1, 8'h66, 1'b0);
    wait_drain("t6_long", 600);
    chk("t6_start_count", start_cnt - s0, 1);
    chk("t6_ready_count", rdy1_cnt - r0, 1);
    frame_len = 20;

    // Gap timing on the GAP_TICKS=3 and GAP_TICKS=0 instances.
    for (int g = 0; g < 2; g++) begin
      int cf, st, n3, k3, exp_st, m;
      @(posedge clk); #1;
      gv[g] = 4'b0011; gl[g] = 4'b1111; gd[g] = 32'h0000_2211;
      m = 0;
      while (!gstart[g] && m < 50) begin @(negedge clk); m++; end
      chk("gap_first_start", gstart[g], 1);
      chk("gap_first_byte", gtx[g], 8'h11);
      @(posedge clk); #1;
      gv[g][0] = 1'b0; gbusy[g] = 1'b1;
      repeat (15) @(posedge clk);
      #1; gbusy[g] = 1'b0; cf = cyc;
      n3 = 0; k3 = -100; st = -1; m = 0;
      while (st < 0 && m < 100) begin
        @(negedge clk); m++;
        if (g_enb && cyc > cf) begin
          n3++;
          if (n3 == 3) k3 = cyc;
        end
        if (gstart[g]) st = cyc;
      end
      exp_st = (g == 0) ? k3 + 2 : cf + 2;
      chk("gap_second_start_cycle", st, exp_st);
      chk("gap_second_byte", gtx[g], 8'h22);
      chk("gap_second_grant", gid[g], 1);
      @(posedge clk); #1;
      gv[g] = '0;
    end

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART 8N1 transmitter among N_REQ byte producers.
- Round-robin grant; a requester can lock the transmitter for a multi-byte message using req_last.
- Enforces a minimum idle gap after each frame, counted in baud ticks from the baud rate generator's tx_enb.
- Sits between the producer blocks and uart_tx; tx_enb comes from baud_rate_gen.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- GAP_TICKS, 1, idle baud ticks after tx_busy falls before the next grant (0 = no gap).
- GAP_W, 4, width of the gap counter; GAP_TICKS < 2**GAP_W.
- ID_W, 2, width of the grant index; equals clog2(N_REQ).

Ports:
- clk, in, 1, system clock.
- rst, in, 1, synchronous reset, active-high.
- req_valid, in, N_REQ, per-requester byte available.
- req_data, in, 8*N_REQ, byte of requester i at bits [8i+7:8i].
- req_last, in, N_REQ, byte ends the message; 0 keeps the lock.
- req_ready, out, N_REQ, one-cycle accept pulse to the granted requester.
- tx_enb, in, 1, baud tick from baud_rate_gen.
- tx_busy, in, 1, uart_tx frame in progress.
- tx_start, out, 1, one-cycle start strobe to uart_tx.
- tx_data, out, 8, byte to uart_tx; valid while tx_start=1, held afterwards.
- grant_id, out, ID_W, index of the current or last grantee.
- locked, out, 1, message lock active.

Behaviour:
- Clock and reset: reset rst, synchronous, active-high; clock clk.
- Reset values: all outputs 0; state IDLE; rr_ptr=0; lock cleared; gap counter 0.
- Requester rule: req_valid, req_data and req_last are held stable from assertion until req_ready. The arbiter does not check this rule.
- IDLE:
  - Locked: wait for req_valid[locked_id] only; all others are blocked.
  - Unlocked: scan from rr_ptr upward, mod N_REQ. The first asserted req_valid becomes the grant, registered into grant_id.
  - Any grant moves to ISSUE on the next cycle.
- ISSUE (1 cycle):
  - tx_start=1, tx_data=req_data[grant], req_ready[grant]=1.
  - req_last=0: set locked, locked_id=grant.
  - req_last=1: clear locked; rr_ptr <= grant+1 mod N_REQ.
  - Next state is WAIT_BUSY.
- WAIT_BUSY: stay until tx_busy=1, then go to WAIT_DONE. uart_tx raises tx_busy within 1 clk of tx_start.
- WAIT_DONE: stay until tx_busy=0.
  - GAP_TICKS=0: go to IDLE.
  - Otherwise: load gap counter with GAP_TICKS and go to GAP.
- GAP: decrement on each cycle with tx_enb=1. When the counter reaches 0, go to IDLE on the same cycle as that tick. Ticks seen outside GAP are ignored.
- Latency: req_valid rising in IDLE to tx_start is 2 clk (grant cycle plus ISSUE).
- Throughput: one byte per frame time plus the gap.
- rr_ptr advances only at message end. A locked message is never interleaved.
- Wrap: rr_ptr moves from N_REQ-1 back to 0.
- Simultaneous requests: the lowest index at or after rr_ptr wins.
- tx_busy already high on entry to WAIT_BUSY: go to WAIT_DONE on the next cycle.
- rst mid-frame: returns to IDLE and drops the lock. No tx_start is issued on the reset cycle or the cycle after it.
- Invariant: req_ready is one-hot or zero and is asserted only in ISSUE.

Decomposition:
- Shared package (uart_pkg): state encoding IDLE/ISSUE/WAIT_BUSY/WAIT_DONE/GAP, and the default values of N_REQ and GAP_TICKS.
- One sub-module: rr_pick. Combinational round-robin priority picker taking a request vector and rr_ptr, returning a found flag and an index. It is also reused for future rx-side routing.

Test Plan:
1. Basic byte: after reset, req_valid=0001 with data 0x55, last=1. Expect tx_start at cycle +2 with tx_data=0x55, a req_ready[0] pulse in the same cycle, and no second tx_start until tx_busy falls and 1 tx_enb tick passes.
2. Round-robin: all four requesters valid, last=1, data 0xA0..0xA3. Expect transmit order 0,1,2,3, then req 0 again if it is re-asserted. With rr_ptr=2 and requests 0011, expect 0 before 1.
3. Message lock: req1 sends 0x10 (last=0), 0x11 (last=0), 0x12 (last=1) while req0 and req2 stay valid. Expect three consecutive grants to 1 with locked=1, locked=0 after 0x12, and the next grant to 2.
4. Gap: GAP_TICKS=3 with tx_enb every 10 clk. Expect the next tx_start no earlier than the third tx_enb after tx_busy falls. With GAP_TICKS=0, expect the next tx_start 2 clk after tx_busy falls.
5. Reset mid-message: assert rst during WAIT_DONE while locked. Expect all outputs 0 and locked=0; req2 is then granted normally.
6. Immediate busy: a model that holds tx_busy=1 on the cycle after ISSUE and clears it after 100 clk. Expect no duplicate tx_start and req_ready pulsed exactly once.
